// File: rtl/npu_cbuf_config_loader.sv
// ---------------------------------------------------------------------------
// npu_cbuf_config_loader
//
// Purpose:
//   Loads a framed configuration stream (header word N followed by N data
//   words) into the NPU weight/scheduling circular buffer. It then serves
//   consumer read requests against that buffer, tracking the position and
//   the wrap of the recirculating sequence. The write and read enables are
//   never high together. Reads are issued only after a complete load, so the
//   buffer can neither overflow nor underflow.
//
// Ports:
//   CLK                      global clock
//   npu_rst                  async active-high reset; also the reload path
//   load_start               pulse, starts a load (IDLE only)
//   cfg_data_in / cfg_valid  config stream word and its valid
//   cfg_ready                loader accepts the stream word this cycle
//   run_en                   level, enables serving read requests
//   step_req / step_ready    consumer request handshake
//   npu_circ_buf_write_en    buffer write enable (registered)
//   npu_circ_buf_read_en     buffer read enable (registered)
//   npu_circ_buf_data_input  buffer write data (registered)
//   word_valid               buffer dout valid this cycle
//   word_index               index (0..N-1) of the word on buffer dout
//   word_last                word_valid and word_index == N-1
//   loaded_count             N after an accepted header, else 0
//   loader_state             encoded state, for debug
//   cfg_error                sticky error: illegal header or checksum failure
//
// Build option:
//   NPU_CBUF_LOADER_CKSUM_EN - when defined, a trailer word equal to the XOR
//   of the N data words follows the data. A mismatch ends in ERR.
//
// States:
//   state   | meaning
//   IDLE  0 | waiting for load_start
//   HDR   1 | accepting the header word (word count N)
//   LOAD  2 | accepting and writing N data words
//   CKSUM 3 | accepting the XOR trailer (checksum build only)
//   READY 4 | loaded, waiting for run_en
//   RUN   5 | serving step requests
//   ERR   7 | illegal header / checksum failure, left only by reset
// ---------------------------------------------------------------------------
module npu_cbuf_config_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8192,
    parameter int CNT_W  = 14
) (
    input  logic              CLK,
    input  logic              npu_rst,
    input  logic              load_start,
    input  logic [DATA_W-1:0] cfg_data_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              run_en,
    input  logic              step_req,
    output logic              step_ready,
    output logic              npu_circ_buf_write_en,
    output logic              npu_circ_buf_read_en,
    output logic [DATA_W-1:0] npu_circ_buf_data_input,
    output logic              word_valid,
    output logic [CNT_W-1:0]  word_index,
    output logic              word_last,
    output logic [CNT_W-1:0]  loaded_count,
    output logic [2:0]        loader_state,
    output logic              cfg_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
`ifdef NPU_CBUF_LOADER_CKSUM_EN
        S_CKSUM = 3'd3,
`endif
        S_READY = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd7
    } state_t;

    state_t            state;
    logic              cfg_rdy_q;
    logic              step_rdy_q;
    logic [CNT_W-1:0]  words_left;   // down-counter of data words still to accept
    logic [CNT_W-1:0]  next_idx;     // index the next accepted step will read
    logic [CNT_W-1:0]  rd_idx;       // index of the read currently in flight
`ifdef NPU_CBUF_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_acc;
`endif

    logic             cfg_acc;
    logic             step_acc;
    logic             hdr_ok;
    logic             n_is_one;
    logic [CNT_W-1:0] last_idx;

    // step_ready falls in the same cycle as run_en so that no request can be
    // accepted once the consumer has stopped the run.
    assign cfg_ready    = cfg_rdy_q;
    assign step_ready   = step_rdy_q & run_en;
    assign cfg_acc      = cfg_valid & cfg_rdy_q;
    assign step_acc     = step_req & step_ready;
    assign hdr_ok       = (cfg_data_in != '0) && (cfg_data_in <= DATA_W'(DEPTH));
    assign last_idx     = loaded_count - CNT_W'(1);
    assign n_is_one     = (loaded_count == CNT_W'(1));
    assign loader_state = state;

    always_ff @(posedge CLK or posedge npu_rst) begin
        if (npu_rst) begin
            state                   <= S_IDLE;
            cfg_rdy_q               <= 1'b0;
            step_rdy_q              <= 1'b0;
            words_left              <= '0;
            next_idx                <= '0;
            rd_idx                  <= '0;
            npu_circ_buf_write_en   <= 1'b0;
            npu_circ_buf_read_en    <= 1'b0;
            npu_circ_buf_data_input <= '0;
            word_valid              <= 1'b0;
            word_index              <= '0;
            word_last               <= 1'b0;
            loaded_count            <= '0;
            cfg_error               <= 1'b0;
`ifdef NPU_CBUF_LOADER_CKSUM_EN
            cksum_acc               <= '0;
`endif
        end else begin
            npu_circ_buf_write_en <= 1'b0;
            npu_circ_buf_read_en  <= 1'b0;

            // Buffer dout follows read_en by one cycle in every state, so a
            // read issued just before leaving RUN still completes.
            word_valid <= npu_circ_buf_read_en;
            word_last  <= npu_circ_buf_read_en && (rd_idx == last_idx);
            if (npu_circ_buf_read_en) begin
                word_index <= rd_idx;
            end

            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state     <= S_HDR;
                        cfg_rdy_q <= 1'b1;
                    end
                end

                S_HDR: begin
                    if (cfg_acc) begin
                        if (hdr_ok) begin
                            loaded_count <= CNT_W'(cfg_data_in);
                            words_left   <= CNT_W'(cfg_data_in);
                            state        <= S_LOAD;
                        end else begin
                            cfg_error <= 1'b1;
                            cfg_rdy_q <= 1'b0;
                            state     <= S_ERR;
                        end
                    end
                end

                S_LOAD: begin
                    if (cfg_acc) begin
                        npu_circ_buf_write_en   <= 1'b1;
                        npu_circ_buf_data_input <= cfg_data_in;
                        words_left              <= words_left - CNT_W'(1);
`ifdef NPU_CBUF_LOADER_CKSUM_EN
                        cksum_acc <= cksum_acc ^ cfg_data_in;
                        if (words_left == CNT_W'(1)) begin
                            state <= S_CKSUM;
                        end
`else
                        if (words_left == CNT_W'(1)) begin
                            cfg_rdy_q <= 1'b0;
                            state     <= S_READY;
                        end
`endif
                    end
                end

`ifdef NPU_CBUF_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (cfg_acc) begin
                        cfg_rdy_q <= 1'b0;
                        if (cfg_data_in == cksum_acc) begin
                            state <= S_READY;
                        end else begin
                            cfg_error <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
`endif

                S_READY: begin
                    if (run_en) begin
                        state      <= S_RUN;
                        step_rdy_q <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (step_acc) begin
                        npu_circ_buf_read_en <= 1'b1;
                        rd_idx               <= next_idx;
                        next_idx             <= (next_idx == last_idx) ? '0
                                                : next_idx + CNT_W'(1);
                    end
                    if (!run_en) begin
                        step_rdy_q <= 1'b0;
                        // Hold RUN until the last issued read has gone out.
                        if (!npu_circ_buf_read_en) begin
                            state <= S_READY;
                        end
                    end else begin
                        // With a single word the buffer rewrites it on read,
                        // so a one-cycle gap follows every accepted step.
                        step_rdy_q <= !(step_acc && n_is_one);
                    end
                end

                S_ERR: begin
                    cfg_rdy_q  <= 1'b0;
                    step_rdy_q <= 1'b0;
                    cfg_error  <= 1'b1;
                end

                default: begin
                    cfg_rdy_q  <= 1'b0;
                    step_rdy_q <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_cbuf_config_loader.sv
module tb_npu_cbuf_config_loader;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8192;
    localparam int CNT_W  = 14;

    logic              CLK = 1'b0;
    logic              npu_rst = 1'b1;
    logic              load_start;
    logic [DATA_W-1:0] cfg_data_in;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              run_en;
    logic              step_req;
    logic              step_ready;
    logic              npu_circ_buf_write_en;
    logic              npu_circ_buf_read_en;
    logic [DATA_W-1:0] npu_circ_buf_data_input;
    logic              word_valid;
    logic [CNT_W-1:0]  word_index;
    logic              word_last;
    logic [CNT_W-1:0]  loaded_count;
    logic [2:0]        loader_state;
    logic              cfg_error;

    npu_cbuf_config_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK                     (CLK),
        .npu_rst                 (npu_rst),
        .load_start              (load_start),
        .cfg_data_in             (cfg_data_in),
        .cfg_valid               (cfg_valid),
        .cfg_ready               (cfg_ready),
        .run_en                  (run_en),
        .step_req                (step_req),
        .step_ready              (step_ready),
        .npu_circ_buf_write_en   (npu_circ_buf_write_en),
        .npu_circ_buf_read_en    (npu_circ_buf_read_en),
        .npu_circ_buf_data_input (npu_circ_buf_data_input),
        .word_valid              (word_valid),
        .word_index              (word_index),
        .word_last               (word_last),
        .loaded_count            (loaded_count),
        .loader_state            (loader_state),
        .cfg_error               (cfg_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [53:0] out_vec;
    assign out_vec = {cfg_ready, step_ready, npu_circ_buf_write_en, npu_circ_buf_read_en,
                      npu_circ_buf_data_input, word_valid, word_index, word_last,
                      loaded_count, loader_state, cfg_error};

    typedef struct {logic [15:0] d; int c;} wr_exp_t;
    typedef struct {int idx; bit last; int c;} rd_exp_t;

    wr_exp_t     wr_q[$];
    rd_exp_t     rd_q[$];
    logic [15:0] words_q[$];
    logic [15:0] trailer;
    int n_cmp = 0;
    int n_err = 0;
    int n_cur = 0;     // model: words in the loaded sequence
    int step_k = 0;    // model: steps accepted since the load
    int gap_max = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected buffer traffic whenever the DUT presents it.
    always @(negedge CLK) begin
        wr_exp_t we;
        rd_exp_t re;
        if (!npu_rst) begin
            if (npu_circ_buf_write_en || npu_circ_buf_read_en)
                chk("rd_wr_overlap", 64'(npu_circ_buf_write_en & npu_circ_buf_read_en), 0);
            if (npu_circ_buf_write_en) begin
                chk("write_expected", 64'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    chk("write_data", npu_circ_buf_data_input, we.d);
                    chk("write_cycle", cyc, we.c);
                end
            end
            if (word_valid) begin
                chk("read_expected", 64'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    re = rd_q.pop_front();
                    chk("word_index", word_index, re.idx);
                    chk("word_last", word_last, re.last);
                    chk("word_cycle", cyc, re.c);
                end
            end else if (word_last) begin
                chk("word_last_without_valid", word_last, 0);
            end
        end
    end

    task automatic idle_inputs();
        load_start  = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data_in = '0;
        run_en      = 1'b0;
        step_req    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 npu_rst = 1'b1;
        idle_inputs();
        #1 chk("reset_outputs", out_vec, 0);
        repeat (2) @(negedge CLK);
        #2 npu_rst = 1'b0;
        n_cur  = 0;
        step_k = 0;
    endtask

    task automatic start_load(input int exp_state);
        @(negedge CLK);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        chk("state_after_load_start", loader_state, exp_state);
    endtask

    task automatic send_word(input logic [15:0] w, input bit is_data);
        bit      done;
        int      gap;
        wr_exp_t e;
        done = 0;
        gap  = $urandom_range(0, gap_max);
        repeat (gap) begin
            @(negedge CLK);
            cfg_valid   = 1'b0;
            cfg_data_in = 16'($urandom);
        end
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge CLK);
            cfg_valid   = 1'b1;
            cfg_data_in = w;
            #1;
            if (cfg_ready) begin
                done = 1;
                if (is_data) begin
                    e.d = w;
                    e.c = cyc + 1;
                    wr_q.push_back(e);
                end
            end
        end
        chk("cfg_accept_timeout", 64'(done), 1);
    endtask

    task automatic make_words(input int n);
        words_q.delete();
        trailer = '0;
        for (int i = 0; i < n; i++) begin
            words_q.push_back(16'($urandom));
            trailer = trailer ^ words_q[i];
        end
    endtask

    // Header, data, optional trailer, then junk held valid to show nothing
    // beyond the frame is taken.
    task automatic load_frame();
        start_load(1);
        send_word(16'(words_q.size()), 1'b0);
        foreach (words_q[i]) send_word(words_q[i], 1'b1);
`ifdef NPU_CBUF_LOADER_CKSUM_EN
        send_word(trailer, 1'b0);
`endif
        n_cur  = words_q.size();
        step_k = 0;
        repeat (2) begin
            @(negedge CLK);
            cfg_valid   = 1'b1;
            cfg_data_in = 16'hDEAD;
            #1 chk("cfg_ready_after_frame", cfg_ready, 0);
        end
        @(negedge CLK);
        cfg_valid = 1'b0;
    endtask

    task automatic expect_loaded(input int n);
        chk("loaded_count", loaded_count, n);
        chk("state_ready", loader_state, 4);
        chk("cfg_error_clear", cfg_error, 0);
    endtask

    task automatic run_steps(input int cycles, input bit hold, input bit chk_toggle);
        bit      seen;
        bit      prev;
        rd_exp_t e;
        seen   = 0;
        prev   = 0;
        run_en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            step_req = hold || ($urandom_range(0, 3) != 0);
            #1;
            if (chk_toggle) begin
                if (seen) chk("n1_step_ready_toggle", step_ready, !prev);
                if (step_ready) seen = 1;
                prev = step_ready;
            end
            if (step_req && step_ready) begin
                e.idx  = step_k % n_cur;
                e.last = (e.idx == n_cur - 1);
                e.c    = cyc + 2;
                rd_q.push_back(e);
                step_k++;
            end
        end
        @(negedge CLK);
        step_req = 1'b0;
        run_en   = 1'b0;
        #1 chk("step_ready_drops_with_run_en", step_ready, 0);
        repeat (4) @(negedge CLK);
        chk("state_back_to_ready", loader_state, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();

        // Fixed four-word frame, continuous valid.
        do_reset();
        gap_max = 0;
        words_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        trailer = 16'h1111 ^ 16'h2222 ^ 16'h3333 ^ 16'h4444;
        load_frame();
        expect_loaded(4);
        start_load(4);                 // ignored in READY
        run_steps(10, 1'b1, 1'b0);
        run_steps(7, 1'b0, 1'b0);      // resumed run continues the sequence

        // Illegal headers: zero and DEPTH+1.
        for (int h = 0; h < 2; h++) begin
            do_reset();
            start_load(1);
            send_word((h == 0) ? 16'd0 : 16'(DEPTH + 1), 1'b0);
            @(negedge CLK);
            cfg_valid = 1'b0;
            #1;
            chk("err_state", loader_state, 7);
            chk("err_flag", cfg_error, 1);
            chk("err_cfg_ready", cfg_ready, 0);
            chk("err_loaded_count", loaded_count, 0);
            start_load(7);
            run_en   = 1'b1;
            step_req = 1'b1;
            @(negedge CLK);
            #1 chk("err_step_ready", step_ready, 0);
            idle_inputs();
        end

        // Boundary header N == DEPTH is legal; abandon it by reset.
        do_reset();
        start_load(1);
        send_word(16'(DEPTH), 1'b0);
        @(negedge CLK);
        cfg_valid = 1'b0;
        chk("depth_header_count", loaded_count, DEPTH);
        chk("depth_header_state", loader_state, 2);

        // Single-word sequence: step_ready alternates.
        do_reset();
        make_words(1);
        load_frame();
        expect_loaded(1);
        run_steps(12, 1'b1, 1'b1);

        // Async reset mid-load after two of four words, then a clean reload.
        do_reset();
        make_words(4);
        start_load(1);
        send_word(16'd4, 1'b0);
        send_word(words_q[0], 1'b1);
        send_word(words_q[1], 1'b1);
        @(negedge CLK);
        #2 npu_rst = 1'b1;
        cfg_valid = 1'b0;
        #1 chk("midload_reset_outputs", out_vec, 0);
        repeat (2) @(negedge CLK);
        #2 npu_rst = 1'b0;
        make_words(4);
        load_frame();
        expect_loaded(4);
        run_steps(9, 1'b0, 1'b0);

`ifdef NPU_CBUF_LOADER_CKSUM_EN
        do_reset();
        words_q = '{16'h00F0, 16'h0F00};
        trailer = 16'h0FF0;
        load_frame();
        expect_loaded(2);
        do_reset();
        words_q = '{16'h00F0, 16'h0F00};
        trailer = 16'h0FF1;
        load_frame();
        chk("cksum_err_state", loader_state, 7);
        chk("cksum_err_flag", cfg_error, 1);
`endif

        // Randomized frames with valid gaps and random step patterns.
        gap_max = 2;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            make_words($urandom_range(1, 12));
            load_frame();
            expect_loaded(words_q.size());
            run_steps($urandom_range(5, 30), 1'b0, 1'b0);
            run_steps($urandom_range(5, 30), 1'b0, 1'b0);
        end

        repeat (4) @(negedge CLK);
        chk("write_queue_drained", wr_q.size(), 0);
        chk("read_queue_drained", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/npu_cbuf_config_loader.md
Name: npu_cbuf_config_loader

Overview:
Drives the write and read side of the NPU weight/scheduling circular buffer (16-bit, 8192-deep, recirculating on read).
- Accepts a framed config stream (header word = word count N, then N data words) from the config FIFO interface over valid/ready.
- Writes the N words into the buffer.
- During run, issues read enables on consumer request, tracking position and wrap of the circular sequence.
- Guarantees the buffer's rules: read and write are never both high, and there is no overflow or underflow.

Parameters:
DATA_W, 16, config/buffer word width
DEPTH, 8192, circular buffer capacity in words
CNT_W, 14, counter width; must satisfy 2^CNT_W > DEPTH

Ports:
CLK  input  1  global 100 MHz clock
npu_rst  input  1  asynchronous active-high reset; also the reload path (buffer is reset by the same signal)
load_start  input  1  pulse; begins a config load (honoured in IDLE only)
cfg_data_in  input  DATA_W  config stream word
cfg_valid  input  1  cfg_data_in valid
cfg_ready  output  1  loader accepts word this cycle
run_en  input  1  level; enables serving read requests
step_req  input  1  consumer requests next word
step_ready  output  1  request accepted when step_req & step_ready
npu_circ_buf_write_en  output  1  buffer write enable (registered)
npu_circ_buf_read_en  output  1  buffer read enable (registered)
npu_circ_buf_data_input  output  DATA_W  buffer write data (registered)
word_valid  output  1  buffer dout valid this cycle
word_index  output  CNT_W  index (0..N-1) of word on buffer dout
word_last  output  1  word_valid & word_index==N-1
loaded_count  output  CNT_W  N after successful header; 0 otherwise
loader_state  output  3  encoded state for debug
cfg_error  output  1  sticky; set on illegal header or checksum failure

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; counters 0. Reset mid-load or mid-run abandons the operation. Reset is the only way out of READY/RUN/ERR and the only way to reload.
- States (loader_state encoding): IDLE=0, HDR=1, LOAD=2, CKSUM=3, READY=4, RUN=5, ERR=7.
- IDLE:
  - load_start -> HDR.
  - load_start is ignored in every other state.
- HDR:
  - cfg_ready=1.
  - On accept, header N with 1<=N<=DEPTH -> loaded_count=N, go to LOAD.
  - N==0 or N>DEPTH -> cfg_error=1, go to ERR.
  - Header is never written to the buffer.
- LOAD:
  - cfg_ready=1.
  - Each accepted word appears on npu_circ_buf_data_input with npu_circ_buf_write_en=1 exactly one cycle later.
  - cfg_valid gaps produce write_en=0 cycles.
  - After the Nth accept -> READY (or CKSUM when the optional feature is enabled).
  - cfg_ready drops in the cycle after the Nth accept; no extra word is accepted.
- READY:
  - run_en=1 -> RUN.
  - step_ready=0.
- RUN:
  - step_ready=1, except the cycle following an accepted step when N==1. This gap lets the buffer rewrite its single word before it is read again.
  - Accepted step -> npu_circ_buf_read_en=1 in the next cycle; word_valid=1 one cycle after read_en (total 2-cycle request-to-data latency).
  - Back-to-back steps are sustained at 1/cycle for N>=2.
  - word_index starts at 0 and increments per word_valid, wrapping N-1 -> 0 with word_last asserted on index N-1.
  - run_en=0 -> step_ready=0 immediately. In-flight read_en/word_valid complete, then go to READY. Index is retained, so a resumed run continues the sequence.
- Write and read enables are never simultaneously 1. Reads only occur after the load completes.
- ERR: cfg_ready=0, step_ready=0, cfg_error=1 until reset.

Optional Feature:
NPU_CBUF_LOADER_CKSUM_EN
- Defined:
  - After the N data words, state CKSUM accepts one trailer word (cfg_ready=1); the trailer is not written to the buffer.
  - Trailer must equal the XOR of all N data words.
  - Match -> READY. Mismatch -> cfg_error=1 and go to ERR; buffer contents are already written but never read.
- Undefined: no CKSUM state; LOAD goes directly to READY; checksum logic is absent.

Test Plan:
- Load header 4, words 0x1111,0x2222,0x3333,0x4444, continuous valid -> write_en high 4 cycles, each one cycle after its accept, with those data values; loaded_count=4; state READY.
- Same load, run_en=1, step_req held 10 cycles -> word_index 0,1,2,3,0,1,2,3,0,1; word_last on the 4th and 8th word_valid; first word_valid 2 cycles after the first accept; read_en never overlaps write_en.
- Header 0, then separately header 8193 -> cfg_error=1, state ERR, no write_en; load_start ignored until npu_rst.
- N=1, step_req held -> step_ready toggles 1,0,1,0; read_en every other cycle; word_index stays 0 and word_last on every word_valid.
- npu_rst asserted mid-LOAD after 2 of 4 words (async, between clock edges) -> all outputs 0 immediately, state IDLE; a fresh load then succeeds.
- With NPU_CBUF_LOADER_CKSUM_EN: words 0x00F0,0x0F00 plus trailer 0x0FF0 -> READY; a load with trailer 0x0FF1 -> cfg_error=1, ERR.
